// File: rtl/counter_pkg.sv
// Shared definitions for the Gray up/down counter: saturation mode encodings
// and a reference binary-to-Gray helper usable at any width up to 32 bits.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Operates on a full 32-bit word; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_conv.sv
// Purely combinational binary-to-Gray conversion of a WIDTH-bit word.
module bin2gray_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_updown_counter.sv
// Bounded up/down counter (0..max_val) with wrap or saturate behaviour, a
// registered terminal-count pulse and a combinational Gray view of the count.
module gray_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_binary;
  logic             r_tc;

  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_load_clamp;
  logic [WIDTH-1:0] w_next;
  logic             w_tc_next;

  // ">=" rather than "==" so a count left above a lowered max_val still wraps/holds
  assign w_at_top     = (r_binary >= max_val);
  assign w_at_bot     = (r_binary == '0);
  assign w_load_clamp = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    w_next    = r_binary;
    w_tc_next = 1'b0;
    if (load) begin
      w_next = w_load_clamp;
    end else if (en) begin
      if (up) begin
        if (w_at_top) begin
          w_next    = (SATURATE == CNT_SAT) ? max_val : '0;
          w_tc_next = 1'b1;
        end else begin
          w_next = r_binary + ONE;
        end
      end else begin
        if (w_at_bot) begin
          w_next    = (SATURATE == CNT_SAT) ? '0 : max_val;
          w_tc_next = 1'b1;
        end else begin
          w_next = r_binary - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_binary <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_binary <= w_next;
      r_tc     <= w_tc_next;
    end
  end

  assign binary = r_binary;
  assign tc     = r_tc;

  bin2gray_conv #(
    .WIDTH (WIDTH)
  ) u_gray (
    .i_bin  (r_binary),
    .o_gray (gray)
  );

endmodule
